// File: rtl/motor_cmd_master_pkg.sv
// Shared constants and FSM encoding for the motor command master.
package motor_cmd_master_pkg;

  // Duty field width; keep in step with DUTY_CYCLE_SIZE in defines.v.
  localparam int DUTY_CYCLE_SIZE = 16;

  localparam int         NUM_MOTORS = 6;
  localparam int         LAST_MOTOR = NUM_MOTORS - 1;
  localparam logic [3:0] CTRL_BASE  = 4'h0;
  localparam logic [3:0] DUTY_BASE  = 4'h8;

  // Control register bit positions
  localparam int CTRL_ON_BIT  = 0;
  localparam int CTRL_DIR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DUTY_WR = 2'd1,
    ST_CTRL_WR = 2'd2,
    ST_STOP_WR = 2'd3
  } mst_state_e;

endpackage

// File: rtl/motor_cmd_master_if.sv
// Command stream + Avalon-MM write bus between source, master and motor slave.
interface motor_cmd_master_if #(
  parameter int DUTY_W = motor_cmd_master_pkg::DUTY_CYCLE_SIZE
);
  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_motor;
  logic              cmd_on;
  logic              cmd_dir;
  logic [DUTY_W-1:0] cmd_duty;
  // Avalon-MM write side
  logic              chipselect;
  logic              write;
  logic [3:0]        address;
  logic [31:0]       writedata;
  logic              waitrequest;

  modport master (
    input  cmd_valid, cmd_motor, cmd_on, cmd_dir, cmd_duty, waitrequest,
    output cmd_ready, chipselect, write, address, writedata
  );

  modport slave (
    output cmd_valid, cmd_motor, cmd_on, cmd_dir, cmd_duty, waitrequest,
    input  cmd_ready, chipselect, write, address, writedata
  );
endinterface

// File: rtl/motor_cmd_master_cmd_fifo.sv
// Small synchronous first-word-fall-through FIFO with flush and full/empty flags.
module cmd_fifo #(
  parameter int DEPTH = 4,   // power of 2, >= 2
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer/count update; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/motor_cmd_master.sv
// Avalon-MM write master: each queued command becomes a duty write then a
// control write; all-stop writes zero to every control register.
module motor_cmd_master import motor_cmd_master_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int DUTY_W     = DUTY_CYCLE_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  motor_cmd_master_if.master  bus,
  input  logic                stop_req,
  output logic                cmd_err,
  output logic                stop_done,
  output logic                busy
);
  localparam int CW = 5 + DUTY_W;   // {motor[2:0], on, dir, duty}

  mst_state_e        state_q, state_d;
  logic [CW-1:0]     cur_q, cur_d;
  logic [2:0]        k_q, k_d;
  logic              stop_pending_q, stop_pending_d;
  logic              cmd_err_q, cmd_err_d;
  logic              stop_done_q, stop_done_d;

  logic              accept, legal, push, pop, flush, stop_now, stop_fin, xfer_done;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_dout;
  logic [2:0]        cur_motor;
  logic              cur_on, cur_dir;
  logic [DUTY_W-1:0] cur_duty;

  assign cur_motor = cur_q[CW-1 -: 3];
  assign cur_on    = cur_q[DUTY_W+1];
  assign cur_dir   = cur_q[DUTY_W];
  assign cur_duty  = cur_q[DUTY_W-1:0];

  assign bus.cmd_ready = ~reset & ~fifo_full & ~stop_pending_q & (state_q != ST_STOP_WR);
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign legal         = (bus.cmd_motor <= 3'(LAST_MOTOR));
  assign push          = accept & legal;
  // A request seen this cycle acts immediately so it beats a queued command.
  assign stop_now      = stop_pending_q | stop_req;
  assign xfer_done     = bus.write & ~bus.waitrequest;
  assign bus.chipselect = bus.write;
  assign busy          = ~fifo_empty | (state_q != ST_IDLE) | stop_pending_q;
  assign cmd_err       = cmd_err_q;
  assign stop_done     = stop_done_q;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .din   ({bus.cmd_motor, bus.cmd_on, bus.cmd_dir, bus.cmd_duty}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state and bus outputs; address/data come from registered state so
  // they hold while waitrequest stalls the transfer.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    k_d           = k_q;
    pop           = 1'b0;
    flush         = 1'b0;
    stop_fin      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    case (state_q)
      ST_IDLE: begin
        if (stop_now) begin
          state_d = ST_STOP_WR;
          k_d     = '0;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = fifo_dout;
          state_d = ST_DUTY_WR;
        end
      end
      ST_DUTY_WR: begin
        bus.write     = 1'b1;
        bus.address   = DUTY_BASE + {1'b0, cur_motor};
        bus.writedata = {{(32-DUTY_W){1'b0}}, cur_duty};
        if (xfer_done) begin
          // when stopping, this command's control write is dropped
          state_d = stop_now ? ST_STOP_WR : ST_CTRL_WR;
          k_d     = '0;
        end
      end
      ST_CTRL_WR: begin
        bus.write                   = 1'b1;
        bus.address                 = CTRL_BASE + {1'b0, cur_motor};
        bus.writedata[CTRL_ON_BIT]  = cur_on;
        bus.writedata[CTRL_DIR_BIT] = cur_dir;
        if (xfer_done) begin
          state_d = stop_now ? ST_STOP_WR : ST_IDLE;
          k_d     = '0;
        end
      end
      ST_STOP_WR: begin
        bus.write   = 1'b1;
        bus.address = CTRL_BASE + {1'b0, k_q};
        if (xfer_done) begin
          if (k_q == 3'(LAST_MOTOR)) begin
            flush    = 1'b1;
            stop_fin = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Side flags: stop latch, error and done pulses.
  always_comb begin
    stop_pending_d = stop_fin ? 1'b0 : (stop_pending_q | stop_req);
    cmd_err_d      = accept & ~legal;
    stop_done_d    = stop_fin;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cur_q          <= '0;
      k_q            <= '0;
      stop_pending_q <= 1'b0;
      cmd_err_q      <= 1'b0;
      stop_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      k_q            <= k_d;
      stop_pending_q <= stop_pending_d;
      cmd_err_q      <= cmd_err_d;
      stop_done_q    <= stop_done_d;
    end
  end

endmodule

// File: tb/tb_motor_cmd_master.sv
// Bench for motor_cmd_master: directed scenarios plus a random command stream
// scored against a transaction-level expectation of the Avalon writes.
module tb_motor_cmd_master;
  localparam int DW    = motor_cmd_master_pkg::DUTY_CYCLE_SIZE;
  localparam int NRAND = 40;

  typedef struct { int cyc; logic [3:0] addr; logic [31:0] data; } xfer_t;
  typedef struct { int cyc; logic [2:0] m; logic on; logic dir; logic [DW-1:0] duty; } acc_t;

  logic clk = 1'b0;
  logic reset, stop_req, cmd_err, stop_done, busy;
  int   cyc = 0;
  int   n_vec = 0, n_bad = 0;

  xfer_t xfers[$];
  acc_t  acc_q[$];
  int    err_cyc[$];
  int    done_cyc[$];

  motor_cmd_master_if #(.DUTY_W(DW)) bus ();

  motor_cmd_master #(.FIFO_DEPTH(4), .DUTY_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stop_req  (stop_req),
    .cmd_err   (cmd_err),
    .stop_done (stop_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Bus monitor: records transfers, accepts and pulses; checks hold-under-wait.
  logic        w_pend = 1'b0;
  logic [3:0]  p_addr;
  logic [31:0] p_data;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      w_pend = 1'b0;
    end else begin
      if (w_pend) begin
        chk("hold_write", 32'(bus.write), 32'd1);
        chk("hold_addr", 32'(bus.address), 32'(p_addr));
        chk("hold_data", bus.writedata, p_data);
      end
      if (bus.write && !bus.waitrequest)
        xfers.push_back('{cyc: cyc, addr: bus.address, data: bus.writedata});
      w_pend = bus.write && bus.waitrequest;
      p_addr = bus.address;
      p_data = bus.writedata;
      if (bus.cmd_valid && bus.cmd_ready)
        acc_q.push_back('{cyc: cyc, m: bus.cmd_motor, on: bus.cmd_on, dir: bus.cmd_dir, duty: bus.cmd_duty});
      if (cmd_err)   err_cyc.push_back(cyc);
      if (stop_done) done_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    xfers.delete(); acc_q.delete(); err_cyc.delete(); done_cyc.delete();
  endtask

  task automatic drive(input logic [2:0] m, input logic on, input logic dir, input logic [DW-1:0] d);
    bus.cmd_motor = m; bus.cmd_on = on; bus.cmd_dir = dir; bus.cmd_duty = d;
    bus.cmd_valid = 1'b1;
  endtask

  // Expected writes: legal command -> duty write to 8+m, then control {dir,on} to m;
  // illegal command -> no write, error pulse one cycle after acceptance.
  task automatic check_stream(input string tag);
    xfer_t e[$];
    int    ee[$];
    int    n;
    foreach (acc_q[i]) begin
      if (acc_q[i].m < 3'd6) begin
        e.push_back('{cyc: 0, addr: 4'd8 + 4'(acc_q[i].m), data: 32'(acc_q[i].duty)});
        e.push_back('{cyc: 0, addr: 4'(acc_q[i].m), data: {30'd0, acc_q[i].dir, acc_q[i].on}});
      end else begin
        ee.push_back(acc_q[i].cyc + 1);
      end
    end
    chk({tag, "_nxfer"}, 32'(xfers.size()), 32'(e.size()));
    n = (xfers.size() < e.size()) ? xfers.size() : e.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 32'(xfers[i].addr), 32'(e[i].addr));
      chk({tag, "_data"}, xfers[i].data, e[i].data);
    end
    chk({tag, "_nerr"}, 32'(err_cyc.size()), 32'(ee.size()));
    n = (err_cyc.size() < ee.size()) ? err_cyc.size() : ee.size();
    for (int i = 0; i < n; i++) chk({tag, "_errcyc"}, 32'(err_cyc[i]), 32'(ee[i]));
    clear_q();
  endtask

  initial begin
    int c0, sent;
    logic acc;
    reset = 1'b1; stop_req = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_motor = '0; bus.cmd_on = 1'b0; bus.cmd_dir = 1'b0;
    bus.cmd_duty = '0; bus.waitrequest = 1'b0;

    // reset state
    step(3);
    @(negedge clk);
    chk("rst_write", 32'(bus.write), 0);
    chk("rst_cs", 32'(bus.chipselect), 0);
    chk("rst_addr", 32'(bus.address), 0);
    chk("rst_data", bus.writedata, 0);
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    chk("rst_err", 32'(cmd_err), 0);
    chk("rst_done", 32'(stop_done), 0);
    chk("rst_busy", 32'(busy), 0);
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.cmd_ready), 1);
    step(1);
    clear_q();

    // single command, exact latency
    c0 = cyc;
    drive(3'd2, 1'b1, 1'b0, DW'(5));
    @(negedge clk);
    chk("t1_ready", 32'(bus.cmd_ready), 1);
    step(1); bus.cmd_valid = 1'b0;
    step(2);
    @(negedge clk); chk("t1_busy_n3", 32'(busy), 1);
    step(1);
    @(negedge clk); chk("t1_busy_n4", 32'(busy), 0);
    step(3);
    chk("t1_n", 32'(xfers.size()), 2);
    if (xfers.size() == 2) begin
      chk("t1_cyc0", 32'(xfers[0].cyc), 32'(c0 + 2));
      chk("t1_cyc1", 32'(xfers[1].cyc), 32'(c0 + 3));
    end
    check_stream("t1");

    // duty write stalled three cycles
    bus.waitrequest = 1'b1;
    c0 = cyc;
    drive(3'd4, 1'b1, 1'b1, DW'(77));
    step(1); bus.cmd_valid = 1'b0;
    step(3);
    @(negedge clk);
    chk("t2_wr_stall", 32'(bus.write), 1);
    chk("t2_addr_stall", 32'(bus.address), 12);
    step(1); bus.waitrequest = 1'b0;
    step(4);
    chk("t2_n", 32'(xfers.size()), 2);
    if (xfers.size() == 2) begin
      chk("t2_cyc0", 32'(xfers[0].cyc), 32'(c0 + 5));
      chk("t2_cyc1", 32'(xfers[1].cyc), 32'(c0 + 6));
    end
    check_stream("t2");

    // five back-to-back commands into a stalled bus
    bus.waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(3'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), DW'($urandom));
      @(negedge clk);
      chk("t3_ready", 32'(bus.cmd_ready), 1);
      step(1);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_full", 32'(bus.cmd_ready), 0);
    step(1); bus.waitrequest = 1'b0;
    step(20);
    chk("t3_busy", 32'(busy), 0);
    check_stream("t3");

    // illegal indices
    drive(3'd6, 1'b1, 1'b1, DW'(9));
    step(1);
    drive(3'd7, 1'b0, 1'b1, DW'(3));
    step(1); bus.cmd_valid = 1'b0;
    step(6);
    chk("t4_busy", 32'(busy), 0);
    check_stream("t4");

    // all-stop during a duty write with two commands queued
    bus.waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'(i + 1), 1'b1, 1'b0, DW'(100 + i));
      step(1);
    end
    bus.cmd_valid = 1'b0;
    stop_req = 1'b1;
    step(1); stop_req = 1'b0;
    @(negedge clk);
    chk("t5_ready_stop", 32'(bus.cmd_ready), 0);
    step(1); bus.waitrequest = 1'b0;
    for (int i = 0; i < 40 && done_cyc.size() == 0; i++) step(1);
    chk("t5_done_seen", 32'(done_cyc.size()), 1);
    step(5);
    chk("t5_n", 32'(xfers.size()), 7);
    if (xfers.size() == 7 && done_cyc.size() == 1 && acc_q.size() > 0) begin
      chk("t5_duty_addr", 32'(xfers[0].addr), 32'(4'd8 + 4'(acc_q[0].m)));
      chk("t5_duty_data", xfers[0].data, 32'(acc_q[0].duty));
      for (int k = 0; k < 6; k++) begin
        chk("t5_stop_addr", 32'(xfers[k + 1].addr), 32'(k));
        chk("t5_stop_data", xfers[k + 1].data, 0);
        chk("t5_stop_cyc", 32'(xfers[k + 1].cyc), 32'(xfers[0].cyc + 1 + k));
      end
      chk("t5_done_cyc", 32'(done_cyc[0]), 32'(xfers[6].cyc + 1));
    end
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready_after", 32'(bus.cmd_ready), 1);
    clear_q();

    // reset in the middle of a stalled control write
    c0 = cyc;
    drive(3'd5, 1'b1, 1'b1, DW'(42));
    step(1); bus.cmd_valid = 1'b0;
    step(2); bus.waitrequest = 1'b1;
    step(1); reset = 1'b1;
    step(1); reset = 1'b0; bus.waitrequest = 1'b0;
    @(negedge clk);
    chk("t6_write", 32'(bus.write), 0);
    chk("t6_addr", 32'(bus.address), 0);
    chk("t6_busy", 32'(busy), 0);
    step(6);
    chk("t6_n", 32'(xfers.size()), 1);
    clear_q();

    // random command stream with random stalls
    sent = 0;
    for (int cy = 0; cy < 4000; cy++) begin
      if (!bus.cmd_valid && sent < NRAND && $urandom_range(0, 1) == 0)
        drive(3'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
      bus.waitrequest = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      if (acc) sent++;
      if (sent == NRAND && !acc && !bus.cmd_valid && !busy) break;
      step(1);
      if (acc) bus.cmd_valid = 1'b0;
    end
    chk("rnd_sent", 32'(sent), NRAND);
    chk("rnd_idle", 32'(busy), 0);
    step(1); bus.waitrequest = 1'b0;
    step(2);
    check_stream("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
